// File: rtl/wb_flag_stage_pkg.sv
// Shared opcode constants, pipeline state type and flag-update decode for the
// execute/writeback boundary.
package cpu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int REG_AW_DEF = 3;

  localparam logic [8:0] OP_NOP   = 9'd0;
  localparam logic [8:0] OP_ADD   = 9'd1;
  localparam logic [8:0] OP_MOV   = 9'd6;
  localparam logic [8:0] OP_NOT   = 9'd8;
  localparam logic [8:0] OP_SHOWR = 9'd18;
  localparam logic [8:0] OP_CMP   = 9'd20;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } stage_state_e;

  // Arithmetic/logic ops and compare write the status register; moves, not,
  // showR and all unlisted opcodes leave it alone.
  function automatic logic updates_flags(input logic [8:0] alu_op);
    return ((alu_op >= 9'd1) && (alu_op <= 9'd5)) ||
           ((alu_op >= 9'd9) && (alu_op <= 9'd16)) ||
           (alu_op == OP_CMP);
  endfunction

endpackage

// File: rtl/wb_flag_stage_if.sv
// Execute-to-writeback bundle: ALU results in, registered writeback, redirect,
// flags and display outputs back.
interface wb_flag_stage_if #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3
);
  logic              i_valid;
  logic              i_stall;
  logic [8:0]        i_aluOp;
  logic [DATA_W-1:0] i_res;
  logic              i_write;
  logic [REG_AW-1:0] i_dst;
  logic              i_isBranch;
  logic              i_branchResult;
  logic [DATA_W-1:0] i_branchTarget;
  logic              i_zeroFlag;
  logic              i_carryFlag;
  logic              i_signFlag;
  logic              i_overflowFlag;

  logic              o_zeroFlag;
  logic              o_carryFlag;
  logic              o_signFlag;
  logic              o_overflowFlag;
  logic              o_rf_we;
  logic [REG_AW-1:0] o_rf_waddr;
  logic [DATA_W-1:0] o_rf_wdata;
  logic              o_redirect;
  logic [DATA_W-1:0] o_redirect_pc;
  logic              o_flush;
  logic [DATA_W-1:0] o_show_data;
  logic              o_show_valid;

  modport master (
    output i_valid, i_stall, i_aluOp, i_res, i_write, i_dst, i_isBranch,
           i_branchResult, i_branchTarget, i_zeroFlag, i_carryFlag,
           i_signFlag, i_overflowFlag,
    input  o_zeroFlag, o_carryFlag, o_signFlag, o_overflowFlag, o_rf_we,
           o_rf_waddr, o_rf_wdata, o_redirect, o_redirect_pc, o_flush,
           o_show_data, o_show_valid
  );

  modport slave (
    input  i_valid, i_stall, i_aluOp, i_res, i_write, i_dst, i_isBranch,
           i_branchResult, i_branchTarget, i_zeroFlag, i_carryFlag,
           i_signFlag, i_overflowFlag,
    output o_zeroFlag, o_carryFlag, o_signFlag, o_overflowFlag, o_rf_we,
           o_rf_waddr, o_rf_wdata, o_redirect, o_redirect_pc, o_flush,
           o_show_data, o_show_valid
  );
endinterface

// File: rtl/wb_flag_stage_flag_reg.sv
// Architectural Z/C/S/O status register with load enable.
module flag_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] flags_d,
  output logic [3:0] flags_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  flags_q <= 4'b0000;
    else if (en) flags_q <= flags_d;
  end

endmodule

// File: rtl/wb_flag_stage.sv
// Writeback/flag stage: registers ALU results, owns the status register and
// squashes the shadow instructions that follow a taken branch.
module wb_flag_stage
  import cpu_pkg::*;
#(
  parameter int FLUSH_DEPTH = 2,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int REG_AW      = REG_AW_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  wb_flag_stage_if.slave bus
);

  localparam int CNT_W = (FLUSH_DEPTH > 0) ? $clog2(FLUSH_DEPTH + 1) : 1;

  stage_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              redirect_q, redirect_d;
  logic [DATA_W-1:0] redirect_pc_q, redirect_pc_d;
  logic [DATA_W-1:0] show_data_q, show_data_d;
  logic              show_valid_q, show_valid_d;

  logic acc, squash, live, taken, flag_en;
  logic [3:0] flags_q;

  always_comb begin
    acc     = bus.i_valid & ~bus.i_stall;
    squash  = acc & (state_q == FLUSH);
    live    = acc & ~squash;
    taken   = live & bus.i_isBranch & bus.i_branchResult;
    flag_en = live & updates_flags(bus.i_aluOp);

    rf_we_d       = live & bus.i_write;
    rf_waddr_d    = rf_we_d ? bus.i_dst : rf_waddr_q;
    rf_wdata_d    = rf_we_d ? bus.i_res : rf_wdata_q;
    redirect_d    = taken;
    redirect_pc_d = taken ? bus.i_branchTarget : redirect_pc_q;
    show_valid_d  = live & (bus.i_aluOp == OP_SHOWR);
    show_data_d   = show_valid_d ? bus.i_res : show_data_q;

    state_d = state_q;
    cnt_d   = cnt_q;
    // Only accepted slots consume the squash budget; stalls and bubbles hold it.
    if (squash) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) state_d = RUN;
    end else if (taken && (FLUSH_DEPTH > 0)) begin
      state_d = FLUSH;
      cnt_d   = CNT_W'(FLUSH_DEPTH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      rf_we_q       <= 1'b0;
      rf_waddr_q    <= '0;
      rf_wdata_q    <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      show_data_q   <= '0;
      show_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rf_we_q       <= rf_we_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_wdata_q    <= rf_wdata_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      show_data_q   <= show_data_d;
      show_valid_q  <= show_valid_d;
    end
  end

  flag_reg u_flag_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (flag_en),
    .flags_d ({bus.i_zeroFlag, bus.i_carryFlag, bus.i_signFlag, bus.i_overflowFlag}),
    .flags_q (flags_q)
  );

  assign {bus.o_zeroFlag, bus.o_carryFlag, bus.o_signFlag, bus.o_overflowFlag} = flags_q;
  assign bus.o_rf_we       = rf_we_q;
  assign bus.o_rf_waddr    = rf_waddr_q;
  assign bus.o_rf_wdata    = rf_wdata_q;
  assign bus.o_redirect    = redirect_q;
  assign bus.o_redirect_pc = redirect_pc_q;
  assign bus.o_flush       = (state_q == FLUSH);
  assign bus.o_show_data   = show_data_q;
  assign bus.o_show_valid  = show_valid_q;

endmodule

// File: tb/tb_wb_flag_stage.sv
// Self-checking bench for wb_flag_stage: directed scenarios followed by random
// traffic, all compared against a behavioural model of the stage.
module tb_wb_flag_stage;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  wb_flag_stage_if #(.DATA_W(8), .REG_AW(3)) bus ();

  wb_flag_stage #(.FLUSH_DEPTH(DEPTH), .DATA_W(8), .REG_AW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Model state: what the stage should be showing after each edge.
  logic       eWe, eRedir, eShowV;
  logic [2:0] eAddr;
  logic [7:0] eData, ePc, eShow;
  logic [3:0] eFlags;
  int         shadowLeft;

  function automatic bit setsFlags(input int op);
    return op inside {[1:5], [9:16], 20};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    eWe = 0; eRedir = 0; eShowV = 0; eAddr = 0; eData = 0; ePc = 0;
    eShow = 0; eFlags = 0; shadowLeft = 0;
  endtask

  task automatic modelEdge();
    bit accepted, shadow, live, taken;
    accepted = bus.i_valid && !bus.i_stall;
    shadow   = accepted && (shadowLeft > 0);
    live     = accepted && !shadow;
    taken    = live && bus.i_isBranch && bus.i_branchResult;
    eWe      = live && bus.i_write;
    if (eWe) begin eAddr = bus.i_dst; eData = bus.i_res; end
    eRedir = taken;
    if (taken) ePc = bus.i_branchTarget;
    eShowV = live && (bus.i_aluOp == 9'd18);
    if (eShowV) eShow = bus.i_res;
    if (live && setsFlags(int'(bus.i_aluOp)))
      eFlags = {bus.i_zeroFlag, bus.i_carryFlag, bus.i_signFlag, bus.i_overflowFlag};
    if (shadow) shadowLeft--;
    else if (taken) shadowLeft = DEPTH;
  endtask

  task automatic checkAll(input string ph);
    checkOutput({ph, "_rf_we"},    32'(bus.o_rf_we),       32'(eWe));
    checkOutput({ph, "_rf_waddr"}, 32'(bus.o_rf_waddr),    32'(eAddr));
    checkOutput({ph, "_rf_wdata"}, 32'(bus.o_rf_wdata),    32'(eData));
    checkOutput({ph, "_flags"},
                32'({bus.o_zeroFlag, bus.o_carryFlag, bus.o_signFlag, bus.o_overflowFlag}),
                32'(eFlags));
    checkOutput({ph, "_redirect"}, 32'(bus.o_redirect),    32'(eRedir));
    checkOutput({ph, "_redir_pc"}, 32'(bus.o_redirect_pc), 32'(ePc));
    checkOutput({ph, "_flush"},    32'(bus.o_flush),       32'(shadowLeft > 0));
    checkOutput({ph, "_show_d"},   32'(bus.o_show_data),   32'(eShow));
    checkOutput({ph, "_show_v"},   32'(bus.o_show_valid),  32'(eShowV));
  endtask

  // Drive one slot, clock it, update the model and check 1 ns after the edge.
  task automatic applyStimulus(input bit v, input bit st, input int op, input int res,
                               input bit wr, input int dst, input bit br, input bit brr,
                               input int tgt, input logic [3:0] fl, input string ph);
    bus.i_valid = v; bus.i_stall = st; bus.i_aluOp = 9'(op); bus.i_res = 8'(res);
    bus.i_write = wr; bus.i_dst = 3'(dst); bus.i_isBranch = br;
    bus.i_branchResult = brr; bus.i_branchTarget = 8'(tgt);
    {bus.i_zeroFlag, bus.i_carryFlag, bus.i_signFlag, bus.i_overflowFlag} = fl;
    @(posedge clk);
    modelEdge();
    #1;
    checkAll(ph);
  endtask

  initial begin
    int ops[] = '{0, 1, 2, 3, 5, 6, 7, 8, 9, 12, 16, 17, 18, 19, 20, 21, 196};
    modelReset();
    bus.i_valid = 0; bus.i_stall = 0; bus.i_aluOp = 0; bus.i_res = 0; bus.i_write = 0;
    bus.i_dst = 0; bus.i_isBranch = 0; bus.i_branchResult = 0; bus.i_branchTarget = 0;
    bus.i_zeroFlag = 0; bus.i_carryFlag = 0; bus.i_signFlag = 0; bus.i_overflowFlag = 0;
    #2;
    checkAll("reset");
    #10 rst_n = 1'b1;

    // add with Z=C=1 writes r3 and sets flags
    applyStimulus(1, 0, 1, 8'h00, 1, 3, 0, 0, 0, 4'b1100, "add");
    checkOutput("tp_add_we", 32'(bus.o_rf_we), 32'd1);
    checkOutput("tp_add_waddr", 32'(bus.o_rf_waddr), 32'd3);
    checkOutput("tp_add_z", 32'(bus.o_zeroFlag), 32'd1);
    // mov leaves flags alone but still writes
    applyStimulus(1, 0, 6, 8'h77, 1, 5, 0, 0, 0, 4'b0000, "mov");
    checkOutput("tp_mov_z", 32'(bus.o_zeroFlag), 32'd1);
    // taken jump, two squashed adds, third add lands
    applyStimulus(1, 0, 7, 0, 0, 0, 1, 1, 8'h40, 4'b0000, "jmp");
    checkOutput("tp_jmp_pc", 32'(bus.o_redirect_pc), 32'h40);
    applyStimulus(1, 0, 1, 8'h11, 1, 1, 0, 0, 0, 4'b0011, "shadow1");
    applyStimulus(1, 0, 1, 8'h22, 1, 2, 0, 0, 0, 4'b0011, "shadow2");
    checkOutput("tp_shadow_we", 32'(bus.o_rf_we), 32'd0);
    applyStimulus(1, 0, 1, 8'h33, 1, 4, 0, 0, 0, 4'b0011, "post_flush");
    checkOutput("tp_post_we", 32'(bus.o_rf_we), 32'd1);
    // stalls inside a flush window hold the squash count
    applyStimulus(1, 0, 7, 0, 0, 0, 1, 1, 8'h80, 4'b0000, "jmp2");
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, i, 1, 6, 0, 0, 0, 4'b1111, "stall");
    checkOutput("tp_stall_flush", 32'(bus.o_flush), 32'd1);
    applyStimulus(1, 0, 1, 8'h44, 1, 6, 1, 1, 8'h99, 4'b1111, "shadow_br");
    applyStimulus(1, 0, 1, 8'h45, 1, 6, 0, 0, 0, 4'b1111, "shadow_last");
    checkOutput("tp_flush_done", 32'(bus.o_flush), 32'd0);
    // showR value persists across later ops
    applyStimulus(1, 0, 18, 8'hA5, 0, 0, 0, 0, 0, 4'b0000, "showr");
    checkOutput("tp_show_v", 32'(bus.o_show_valid), 32'd1);
    applyStimulus(1, 0, 2, 8'h01, 1, 1, 0, 0, 0, 4'b0001, "after_show");
    checkOutput("tp_show_hold", 32'(bus.o_show_data), 32'hA5);
    // asynchronous reset in the middle of a flush
    applyStimulus(1, 0, 20, 0, 0, 0, 1, 1, 8'h10, 4'b1010, "jmp3");
    #3 rst_n = 1'b0;
    #1;
    modelReset();
    checkAll("async_rst");
    #3 rst_n = 1'b1;
    applyStimulus(1, 0, 1, 8'h5A, 1, 7, 0, 0, 0, 4'b0010, "first_after_rst");
    checkOutput("tp_rst_we", 32'(bus.o_rf_we), 32'd1);

    for (int n = 0; n < 600; n++) begin
      applyStimulus($urandom_range(99) < 80, $urandom_range(99) < 20,
                    ops[$urandom_range(ops.size() - 1)], int'($urandom_range(255)),
                    1'($urandom_range(1)), int'($urandom_range(7)),
                    $urandom_range(99) < 25, 1'($urandom_range(1)),
                    int'($urandom_range(255)), 4'($urandom_range(15)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
